// File: rtl/snax_data_reshuffler_tiled.sv
// Tiled streamer-to-streamer reshuffler: passthrough, transpose and row-reverse layouts over CSR-bounded runs.
// Define SNAX_RESHUFFLER_PERF_EN to add a RUN-time output stall counter as RO register 2.

// Generic synchronous FIFO used to decouple the reshuffler input from its output.
// Latency: a pushed entry is visible at head_dat on the next cycle.
// Backpressure: the caller must push only when !full or when popping in the same cycle.
module snax_reshuffler_fifo #(
   parameter int Width = 8,
   parameter int Depth = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_vld,
   input  logic [Width-1:0] push_dat,
   input  logic             pop_rdy,
   output logic [Width-1:0] head_dat,
   output logic             empty,
   output logic             full
);
   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             push, pop;

   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == CntW'(Depth));
   assign push     = push_vld && (!full || pop_rdy);
   assign pop      = pop_rdy && !empty;
   assign head_dat = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= push_dat;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CntW'(1);
            2'b01:   cnt_q <= cnt_q - CntW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// Reshuffles one tile per beat according to the CSR-latched mode, for num_tiles beats per run.
// Latency: a tile accepted at edge N is presented at the output in cycle N+1 when the FIFO was empty.
// Backpressure: input ready drops when the FIFO is full unless the output is popping that cycle.
module snax_data_reshuffler_tiled #(
   parameter int DataWidth    = 512,
   parameter int ElemWidth    = 8,
   parameter int TileRows     = 8,
   parameter int FifoDepth    = 2,
   parameter int RegRWCount   = 2,
`ifdef SNAX_RESHUFFLER_PERF_EN
   parameter int RegROCount   = 3,
`else
   parameter int RegROCount   = 2,
`endif
   parameter int RegDataWidth = 32
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [DataWidth-1:0]                   stream2acc_0_data_i,
   input  logic                                   stream2acc_0_valid_i,
   output logic                                   stream2acc_0_ready_o,
   output logic [DataWidth-1:0]                   acc2stream_0_data_o,
   output logic                                   acc2stream_0_valid_o,
   input  logic                                   acc2stream_0_ready_i,
   input  logic [RegRWCount-1:0][RegDataWidth-1:0] csr_reg_set_i,
   input  logic                                   csr_reg_set_valid_i,
   output logic                                   csr_reg_set_ready_o,
   output logic [RegROCount-1:0][RegDataWidth-1:0] csr_reg_ro_set_o
);
   localparam int TileCols     = DataWidth / ElemWidth / TileRows;
   localparam bit CanTranspose = (TileRows == TileCols);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   logic [0:0]              state_q;
   logic [1:0]              mode_q;
   logic [RegDataWidth-1:0] num_tiles_q, in_cnt_q, out_cnt_q, tiles_done_q;
   logic                    run, csr_hs, in_hs, out_hs, last_out;
   logic                    fifo_empty, fifo_full;
   logic [DataWidth-1:0]    fifo_head, tile_trans, tile_rrev, tile_xfm;
   logic                    unused_csr;

   assign unused_csr = ^csr_reg_set_i;

   // Non-square tiles have no in-place transpose, so mode 1 degrades to passthrough.
   generate
      if (CanTranspose) begin : g_trans
         always_comb begin
            tile_trans = stream2acc_0_data_i;
            for (int r = 0; r < TileRows; r++) begin
               for (int c = 0; c < TileCols; c++) begin
                  tile_trans[(c*TileCols+r)*ElemWidth +: ElemWidth] =
                     stream2acc_0_data_i[(r*TileCols+c)*ElemWidth +: ElemWidth];
               end
            end
         end
      end else begin : g_no_trans
         assign tile_trans = stream2acc_0_data_i;
      end
   endgenerate

   always_comb begin
      tile_rrev = stream2acc_0_data_i;
      for (int r = 0; r < TileRows; r++) begin
         tile_rrev[r*TileCols*ElemWidth +: TileCols*ElemWidth] =
            stream2acc_0_data_i[(TileRows-1-r)*TileCols*ElemWidth +: TileCols*ElemWidth];
      end
   end

   always_comb begin
      case (mode_q)
         2'd1:    tile_xfm = tile_trans;
         2'd2:    tile_xfm = tile_rrev;
         default: tile_xfm = stream2acc_0_data_i;
      endcase
   end

   assign run                  = (state_q == StRun);
   assign csr_reg_set_ready_o  = !run;
   assign csr_hs               = csr_reg_set_valid_i && csr_reg_set_ready_o;
   assign acc2stream_0_valid_o = !fifo_empty;
   assign out_hs               = acc2stream_0_valid_o && acc2stream_0_ready_i;
   assign stream2acc_0_ready_o = run && (in_cnt_q < num_tiles_q) && (!fifo_full || out_hs);
   assign in_hs                = stream2acc_0_valid_i && stream2acc_0_ready_o;
   assign last_out             = out_hs && (out_cnt_q == num_tiles_q - RegDataWidth'(1));
   // Storage is not reset, so the head is masked to keep the idle output at zero.
   assign acc2stream_0_data_o  = fifo_empty ? '0 : fifo_head;

   snax_reshuffler_fifo #(
      .Width (DataWidth),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_vld (in_hs),
      .push_dat (tile_xfm),
      .pop_rdy  (out_hs),
      .head_dat (fifo_head),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         mode_q       <= '0;
         num_tiles_q  <= '0;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         tiles_done_q <= '0;
      end else begin
         if (csr_hs) begin
            mode_q      <= csr_reg_set_i[0][1:0];
            num_tiles_q <= csr_reg_set_i[1];
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            if (csr_reg_set_i[1] != '0) state_q <= StRun;
         end else if (run) begin
            if (in_hs)    in_cnt_q  <= in_cnt_q + RegDataWidth'(1);
            if (out_hs)   out_cnt_q <= out_cnt_q + RegDataWidth'(1);
            if (last_out) state_q   <= StIdle;
         end
         if (out_hs) tiles_done_q <= tiles_done_q + RegDataWidth'(1);
      end
   end

`ifdef SNAX_RESHUFFLER_PERF_EN
   logic [RegDataWidth-1:0] stall_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || csr_hs) begin
         stall_q <= '0;
      end else if (run && acc2stream_0_valid_o && !acc2stream_0_ready_i && (stall_q != '1)) begin
         stall_q <= stall_q + RegDataWidth'(1);
      end
   end
`endif

   always_comb begin
      csr_reg_ro_set_o    = '0;
      csr_reg_ro_set_o[0] = {{(RegDataWidth-1){1'b0}}, run};
      csr_reg_ro_set_o[1] = tiles_done_q;
`ifdef SNAX_RESHUFFLER_PERF_EN
      csr_reg_ro_set_o[2] = stall_q;
`endif
   end
endmodule

// File: tb/tb_snax_data_reshuffler_tiled.sv
// Directed bench for snax_data_reshuffler_tiled; PERF checks run when SNAX_RESHUFFLER_PERF_EN is defined.
module tb_snax_data_reshuffler_tiled;
   localparam int DW = 512;
`ifdef SNAX_RESHUFFLER_PERF_EN
   localparam int RO = 3;
`else
   localparam int RO = 2;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [DW-1:0]     in_dat;
   logic              in_vld, in_rdy;
   logic [DW-1:0]     out_dat;
   logic              out_vld, acc_rdy;
   logic [1:0][31:0]  csr_set;
   logic              csr_vld, csr_rdy;
   logic [RO-1:0][31:0] ro;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   snax_data_reshuffler_tiled #(
      .DataWidth    (DW),
      .ElemWidth    (8),
      .TileRows     (8),
      .FifoDepth    (2),
      .RegRWCount   (2),
      .RegROCount   (RO),
      .RegDataWidth (32)
   ) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .stream2acc_0_data_i  (in_dat),
      .stream2acc_0_valid_i (in_vld),
      .stream2acc_0_ready_o (in_rdy),
      .acc2stream_0_data_o  (out_dat),
      .acc2stream_0_valid_o (out_vld),
      .acc2stream_0_ready_i (acc_rdy),
      .csr_reg_set_i        (csr_set),
      .csr_reg_set_valid_i  (csr_vld),
      .csr_reg_set_ready_o  (csr_rdy),
      .csr_reg_ro_set_o     (ro)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic csr_write(input logic [1:0] mode, input logic [31:0] n);
      csr_set[0] = {30'd0, mode};
      csr_set[1] = n;
      csr_vld    = 1'b1;
      #1;
      chk("csr_rdy_before_set", csr_rdy, 1);
      tick();
      csr_vld = 1'b0;
   endtask

   // Every byte of row r holds {id, r}.
   function automatic logic [DW-1:0] row_tile(input int id);
      logic [DW-1:0] t;
      for (int k = 0; k < 64; k++) t[k*8 +: 8] = 8'((id << 4) | (k / 8));
      return t;
   endfunction

   // Same tile with rows mirrored: row r holds {id, 7-r}.
   function automatic logic [DW-1:0] rev_tile(input int id);
      logic [DW-1:0] t;
      for (int k = 0; k < 64; k++) t[k*8 +: 8] = 8'((id << 4) | (7 - k / 8));
      return t;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] t_in, t_exp;
      logic [7:0]    b1;
      int            acc_n, out_n;

      rst = 1'b1; in_dat = '0; in_vld = 1'b0; acc_rdy = 1'b0;
      csr_set = '0; csr_vld = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_out_dat", out_dat, 0);
      chk("rst_csr_rdy", csr_rdy, 1);
      chk("rst_ro0", ro[0], 0);
      chk("rst_ro1", ro[1], 0);
      tick();

      // Passthrough, 3 tiles, output always ready
      csr_write(2'd0, 32'd3);
      acc_rdy = 1'b1;
      #1;
      chk("pt_busy", ro[0], 1);
      chk("pt_csr_rdy_run", csr_rdy, 0);
      for (int i = 1; i <= 3; i++) begin
         in_dat = DW'(i); in_vld = 1'b1;
         #1;
         chk("pt_in_rdy", in_rdy, 1);
         if (i > 1) begin
            chk("pt_out_vld", out_vld, 1);
            chk("pt_out_dat", out_dat, DW'(i - 1));
         end
         tick();
      end
      in_vld = 1'b0;
      #1;
      chk("pt_in_rdy_done", in_rdy, 0);
      chk("pt_out_vld_last", out_vld, 1);
      chk("pt_out_dat_last", out_dat, 3);
      tick();
      #1;
      chk("pt_csr_rdy_idle", csr_rdy, 1);
      chk("pt_busy_idle", ro[0], 0);
      chk("pt_tiles_done", ro[1], 3);
      chk("pt_out_vld_idle", out_vld, 0);
      tick();

      // Transpose one 8x8 byte tile
      csr_write(2'd1, 32'd1);
      acc_rdy = 1'b0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            t_in[(r*8+c)*8 +: 8]  = 8'(r*8 + c);
            t_exp[(c*8+r)*8 +: 8] = 8'(r*8 + c);
         end
      in_dat = t_in; in_vld = 1'b1;
      #1;
      chk("tr_in_rdy", in_rdy, 1);
      tick();
      in_vld = 1'b0;
      #1;
      chk("tr_busy", ro[0], 1);
      chk("tr_out_vld", out_vld, 1);
      chk("tr_out_dat", out_dat, t_exp);
      b1 = out_dat[15:8];
      chk("tr_out_byte1", b1, 8'h08);
      acc_rdy = 1'b1;
      tick();
      #1;
      chk("tr_busy_after", ro[0], 0);
      chk("tr_out_vld_after", out_vld, 0);

      // Row-reverse, 4 tiles, output stalled for 5 cycles
      csr_write(2'd2, 32'd4);
      acc_rdy = 1'b0;
      acc_n = 0; out_n = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         in_dat = row_tile(acc_n); in_vld = 1'b1;
         #1;
         if (cyc >= 2) begin
            chk("rr_full_in_rdy", in_rdy, 0);
            chk("rr_hold_vld", out_vld, 1);
            chk("rr_hold_dat", out_dat, rev_tile(0));
         end
         if (in_rdy) acc_n++;
         tick();
      end
      chk("rr_accepted_stalled", acc_n, 2);
      acc_rdy = 1'b1;
      for (int cyc = 0; cyc < 30 && out_n < 4; cyc++) begin
         in_dat = row_tile(acc_n); in_vld = (acc_n < 4);
         #1;
         if (in_vld && in_rdy) acc_n++;
         if (out_vld) begin
            chk("rr_out_dat", out_dat, rev_tile(out_n));
            out_n++;
         end
         tick();
      end
      in_vld = 1'b0;
      chk("rr_out_count", out_n, 4);
      #1;
      chk("rr_busy_after", ro[0], 0);
      chk("rr_tiles_done", ro[1], 8);

      // num_tiles = 0 is a no-op; input valid in IDLE is ignored
      csr_write(2'd0, 32'd0);
      #1;
      chk("zero_csr_rdy", csr_rdy, 1);
      chk("zero_busy", ro[0], 0);
      in_dat = DW'(32'hdead); in_vld = 1'b1;
      #1;
      chk("idle_in_rdy", in_rdy, 0);
      tick();
      #1;
      chk("zero_out_vld", out_vld, 0);
      chk("zero_busy_later", ro[0], 0);
      chk("zero_tiles_done", ro[1], 8);
      in_vld = 1'b0;

      // Reset in the middle of a 5-tile run
      csr_write(2'd0, 32'd5);
      acc_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_dat = DW'(i + 16); in_vld = 1'b1;
         #1;
         chk("mr_in_rdy", in_rdy, 1);
         tick();
      end
      in_vld = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mr_out_vld", out_vld, 0);
      chk("mr_out_dat", out_dat, 0);
      chk("mr_csr_rdy", csr_rdy, 1);
      chk("mr_busy", ro[0], 0);
      chk("mr_tiles_done", ro[1], 0);
      chk("mr_in_rdy_idle", in_rdy, 0);
      csr_write(2'd0, 32'd1);
      acc_rdy = 1'b1;
      in_dat = DW'(8'hab); in_vld = 1'b1;
      #1;
      chk("mr2_in_rdy", in_rdy, 1);
      tick();
      in_vld = 1'b0;
      #1;
      chk("mr2_out_vld", out_vld, 1);
      chk("mr2_out_dat", out_dat, DW'(8'hab));
      tick();
      #1;
      chk("mr2_busy", ro[0], 0);
      chk("mr2_tiles_done", ro[1], 1);

`ifdef SNAX_RESHUFFLER_PERF_EN
      // Stall counter: 7 stalled RUN cycles, cleared by next CSR set
      csr_write(2'd0, 32'd1);
      acc_rdy = 1'b0;
      in_dat = DW'(5); in_vld = 1'b1;
      tick();
      in_vld = 1'b0;
      repeat (7) tick();
      #1;
      chk("perf_stalls", ro[2], 7);
      acc_rdy = 1'b1;
      tick();
      #1;
      chk("perf_busy_after", ro[0], 0);
      chk("perf_stalls_held", ro[2], 7);
      csr_write(2'd0, 32'd0);
      #1;
      chk("perf_cleared", ro[2], 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/snax_data_reshuffler_tiled.md
Name: snax_data_reshuffler_tiled

Overview:
Parametrised successor to the fixed 512-bit transpose reshuffler. Streams tiles from streamer to streamer with CSR-selected layout modes: passthrough, transpose, row-reverse. A CSR-programmed tile count bounds each run, and a FIFO decouples input from output. Sits behind the standard SNAX accelerator shell: streamer ports plus CSR manager set/RO ports.

Parameters:
DataWidth, 512, tile width in bits (one beat = one tile)
ElemWidth, 8, element width in bits; DataWidth % ElemWidth == 0
TileRows, 8, rows per tile; TileCols = DataWidth/ElemWidth/TileRows, must be integral
FifoDepth, 2, output FIFO entries (>=1)
RegRWCount, 2, CSR RW registers
RegROCount, 2, CSR RO registers (3 when SNAX_RESHUFFLER_PERF_EN)
RegDataWidth, 32, CSR width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
stream2acc_0_data_i  in  DataWidth  input tile
stream2acc_0_valid_i  in  1  input valid
stream2acc_0_ready_o  out  1  input ready
acc2stream_0_data_o  out  DataWidth  output tile (FIFO head)
acc2stream_0_valid_o  out  1  output valid
acc2stream_0_ready_i  in  1  output ready
csr_reg_set_i  in  RegRWCount x RegDataWidth  reg0 = mode[1:0], reg1 = num_tiles
csr_reg_set_valid_i  in  1  CSR set valid
csr_reg_set_ready_o  out  1  CSR set ready
csr_reg_ro_set_o  out  RegROCount x RegDataWidth  reg0 = {31'b0, busy}, reg1 = tiles_done

Behaviour:
- Reset (rst_i high at clk edge): state IDLE, FIFO empty, all counters 0.
  - Outputs during/after reset: stream2acc_0_ready_o=0, acc2stream_0_valid_o=0, acc2stream_0_data_o=0, csr_reg_set_ready_o=1, RO regs 0.
  - Reset mid-run discards FIFO contents and counters.
- Element (r,c) occupies bits [(r*TileCols+c)*ElemWidth +: ElemWidth].
- Modes:
  - 0 passthrough.
  - 1 transpose: out(c,r)=in(r,c). Legal only if TileRows==TileCols; otherwise treated as passthrough.
  - 2 row-reverse: out row r = in row TileRows-1-r.
  - 3 reserved: treated as passthrough.
- FSM IDLE/RUN:
  - IDLE: csr_reg_set_ready_o=1, stream2acc_0_ready_o=0.
  - On CSR handshake, latch mode and num_tiles, clear in_cnt/out_cnt.
  - If num_tiles==0, stay IDLE (no-op). Else go to RUN next cycle.
  - RUN: csr_reg_set_ready_o=0; busy=1.
- Input side: stream2acc_0_ready_o = RUN && in_cnt<num_tiles && (!full || output pop this cycle).
  - On input handshake, the transformed tile is pushed to the FIFO and in_cnt increments.
- Latency: tile accepted at edge N appears at output with valid=1 in cycle N+1 if FIFO was empty.
- Output side: valid = !empty; data = FIFO head (held stable while valid && !ready).
  - On output handshake: pop, out_cnt++, tiles_done++.
- Simultaneous push+pop: allowed when full or empty; occupancy unchanged when both occur, except empty+push+pop is impossible since valid=0.
- Run completion: output handshake with out_cnt==num_tiles-1 returns FSM to IDLE next cycle. CSR ready is 1 that cycle.
- Back-to-back runs: a new CSR handshake is accepted the first IDLE cycle.
- Input valid while IDLE or after in_cnt==num_tiles is ignored (ready=0).
- tiles_done is free-running since reset, wraps modulo 2^RegDataWidth, and is not cleared by new CSR sets.
- Counters in_cnt/out_cnt are RegDataWidth wide; num_tiles up to 2^32-1 supported.

Optional Feature:
SNAX_RESHUFFLER_PERF_EN:
- Defined: RegROCount must be 3. csr_reg_ro_set_o[2] = stall counter, +1 every RUN cycle with acc2stream_0_valid_o && !acc2stream_0_ready_i. Cleared on each accepted CSR set and on reset; saturates at all-ones.
- Undefined: no stall counter logic; any RO index >=2 driven to 0.

Test Plan:
- Passthrough: mode=0, num_tiles=3, ready always 1, tiles 0x..01/0x..02/0x..03 -> identical outputs in order, each 1 cycle after acceptance; IDLE after 3rd pop; RO reg1=3.
- Transpose 8x8 bytes: in byte[r*8+c]=r*8+c -> out byte[c*8+r]=r*8+c, e.g. out byte 1 = 0x08; busy=1 during run, 0 after.
- Row-reverse with backpressure: mode=2, num_tiles=4, FifoDepth=2, out ready=0 for 5 cycles -> exactly 2 accepted then input ready=0; after release all 4 emitted, data held stable while stalled.
- Zero/ignored cases: num_tiles=0 -> csr ready stays 1, no input accepted, busy never 1. Input valid in IDLE -> ready 0.
- Reset mid-run: rst_i at tile 2 of 5 -> next cycle valid=0, FIFO empty, counters 0, csr ready=1; new run of 1 tile completes normally.
- PERF_EN: out ready low 7 RUN cycles with valid=1 -> RO reg2=7; new CSR set clears it to 0.
